bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Digit-serial signed BCD adder/subtractor, parametrised in digit count. It is the sequential successor to the combinational HA/FA/BCD-digit adder chain. Magnitudes arrive as packed BCD with separate sign bits. The block processes one BCD digit per clock, LSD first, and runs a second 10's-complement pass when a subtraction goes negative. A start/done handshake lets it sit behind a controller instead of a wide combinational ripple.

## Interface
- DIGITS, 3, number of BCD digits per operand (≥1)
- clk  in  1  clock, rising-edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only when state is IDLE or DONE
- Op  in  1  0 = A+B, 1 = A−B
- SA, SB  in  1  operand signs (1 = negative)
- A, B  in  4*DIGITS  BCD magnitudes, digit 0 in bits [3:0]
- S  out  4*DIGITS  BCD result magnitude
- SS  out  1  result sign
- Cout  out  1  magnitude overflow (result > 10^DIGITS−1)
- err  out  1  an input digit was >9
- busy  out  1  high in ADD and COMP
- done  out  1  one-cycle completion pulse

## Operation
- Reset: state IDLE; S=0, SS=0, Cout=0, err=0, busy=0, done=0; any in-flight operation is discarded.
- States: IDLE, ADD, COMP, DONE.
- IDLE/DONE with start=1:
  - latch A, B, SA, SB, Op;
  - compute eff = SA^SB^Op;
  - set err_l if any digit of A or B >9;
  - digit index := 0; go to ADD.
- start is ignored in ADD/COMP.
- ADD runs one digit per cycle, DIGITS cycles:
  - eff=0: a_i + b_i + c;
  - eff=1: a_i + (9−b_i) + c, with c initialised to 1.
  - If a binary sum >9, add 6 and set the digit carry.
- End of ADD:
  - eff=0: result = sum; Cout = final carry; SS = SA; go to DONE.
  - eff=1 with final carry=1: result = sum; SS = SA; Cout=0; go to DONE.
  - eff=1 with final carry=0: SS = SB^Op; go to COMP.
- COMP runs DIGITS cycles and replaces each sum digit d with (9−d)+c, c initialised to 1, with the same BCD correction. The final carry is discarded. Then go to DONE.
- Zero result forces SS=0.
- err_l=1 forces S=0, SS=0, Cout=0, err=1. Latency is the same as a normal run.
- DONE lasts one cycle, then IDLE. S/SS/Cout/err update only on the transition into DONE and hold until the next transition into DONE.
- Subtraction never sets Cout. An addition overflow leaves the low DIGITS digits (wrapped) in S.

## Timing
- Let E0 be the rising edge that samples start.
- done is high for exactly one cycle, starting after:
  - edge E0+DIGITS (add path, or subtract with carry);
  - edge E0+2·DIGITS (COMP path).
- busy is high from after E0 until the edge that enters DONE.
- start=1 while in DONE is accepted: the next operation begins, done still drops after one cycle, and no idle cycle is required.
- rst asserted at any time clears all state and outputs immediately, without waiting for clk. The first start after rst deasserts follows normal timing.

## Test plan
- DIGITS=3, +123 + +456, Op=0 → after E0+3: S=0x579, SS=0, Cout=0, err=0, done pulse of 1 cycle; busy high 3 cycles.
- +999 + +001 → S=0x000, Cout=1, SS=0, done after E0+3.
- +123 − +456 (Op=1) → COMP path: S=0x333, SS=1, Cout=0, done after E0+6, busy high 6 cycles.
- −500 + +500 → S=0x000 and SS=0 (forced positive). Then −250 − −100 → S=0x150, SS=1.
- A=0x12A + B=0x001 → after E0+3: err=1, S=0, SS=0, Cout=0. The next valid start clears err at its done.
- Robustness sequence:
  - assert start again mid-ADD → ignored, result unchanged;
  - assert rst in the second ADD cycle → all outputs 0 and IDLE asynchronously, no done pulse;
  - restart after rst → correct result.
  - Back-to-back start in DONE → two done pulses 4 cycles apart (DIGITS=3, add path).

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// Digit-serial signed BCD adder/subtractor: one BCD digit per clock, LSD first,
// with a second 10's-complement pass when a subtraction result goes negative.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  Op,
    input  logic                  SA,
    input  logic                  SB,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic [4*DIGITS-1:0]   S,
    output logic                  SS,
    output logic                  Cout,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMP,
        DONE
    } state_e;

    // One decimal digit step: binary add, then +6 correction when the sum passes 9.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [4:0] bin;
        bin = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (bin > 5'd9) begin
            return {1'b1, bin[3:0] + 4'd6};
        end
        return {1'b0, bin[3:0]};
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            sa_q, sa_d;
    logic            csign_q, csign_d;
    logic            eff_q, eff_d;
    logic            errl_q, errl_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    s_q, s_d;
    logic            ss_q, ss_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [4:0]      add_r;
    logic [4:0]      comp_r;
    logic [W-1:0]    add_sum;
    logic [W-1:0]    comp_sum;
    logic            last;
    logic            fin;
    logic [W-1:0]    fin_sum;
    logic            fin_cout;
    logic            fin_sign;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        sa_d     = sa_q;
        csign_d  = csign_q;
        eff_d    = eff_q;
        errl_d   = errl_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        s_d      = s_q;
        ss_d     = ss_q;
        cout_d   = cout_q;
        err_d    = err_q;
        fin      = 1'b0;
        fin_sum  = '0;
        fin_cout = 1'b0;
        fin_sign = 1'b0;

        // Subtraction adds the 9's complement of B; the +1 comes in as the initial carry.
        add_r    = bcd_digit(a_q[3:0], eff_q ? (4'd9 - b_q[3:0]) : b_q[3:0], carry_q);
        comp_r   = bcd_digit(4'd9 - sum_q[3:0], 4'd0, carry_q);
        add_sum  = (sum_q >> 4) | (W'(add_r[3:0]) << (W - 4));
        comp_sum = (sum_q >> 4) | (W'(comp_r[3:0]) << (W - 4));
        last     = (idx_q == LAST_IDX);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sa_d    = SA;
                    csign_d = SB ^ Op;
                    eff_d   = SA ^ SB ^ Op;
                    errl_d  = has_bad_digit(A) | has_bad_digit(B);
                    idx_d   = '0;
                    carry_d = SA ^ SB ^ Op;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = add_sum;
                carry_d = add_r[4];
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d = '0;
                    if (!eff_q) begin
                        fin      = 1'b1;
                        fin_sum  = add_sum;
                        fin_cout = add_r[4];
                        fin_sign = sa_q;
                    end else if (add_r[4]) begin
                        fin      = 1'b1;
                        fin_sum  = add_sum;
                        fin_sign = sa_q;
                    end else begin
                        carry_d = 1'b1;
                        state_d = COMP;
                    end
                end
            end

            COMP: begin
                sum_d   = comp_sum;
                carry_d = comp_r[4];
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d    = '0;
                    fin      = 1'b1;
                    fin_sum  = comp_sum;
                    fin_sign = csign_q;
                end
            end

            default: state_d = IDLE;
        endcase

        // Result registers change only on entry to DONE; bad digits mask the result.
        if (fin) begin
            state_d = DONE;
            if (errl_q) begin
                s_d    = '0;
                ss_d   = 1'b0;
                cout_d = 1'b0;
                err_d  = 1'b1;
            end else begin
                s_d    = fin_sum;
                ss_d   = fin_sign & (fin_sum != '0);
                cout_d = fin_cout;
                err_d  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sa_q    <= 1'b0;
            csign_q <= 1'b0;
            eff_q   <= 1'b0;
            errl_q  <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            ss_q    <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            sa_q    <= sa_d;
            csign_q <= csign_d;
            eff_q   <= eff_d;
            errl_q  <= errl_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            ss_q    <= ss_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign S    = s_q;
    assign SS   = ss_q;
    assign Cout = cout_q;
    assign err  = err_q;
    assign busy = (state_q == ADD) || (state_q == COMP);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: an integer-arithmetic reference model
// predicts each result and latency; a negedge monitor checks every done pulse.
module tb_bcd_serial_addsub;

    localparam int D = 3;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         sa = 1'b0;
    logic         sb = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] s;
    logic         ss, cout, err, busy, done;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Op   (op),
        .SA   (sa),
        .SB   (sb),
        .A    (a),
        .B    (b),
        .S    (s),
        .SS   (ss),
        .Cout (cout),
        .err  (err),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         ss;
        logic         cout;
        logic         err;
        int           e0;
        int           lat;   // 0 = latency not predicted
    } exp_t;

    exp_t scoreboard[$];
    exp_t held;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int m);
        logic [W-1:0] v = '0;
        int           t = m;
        for (int i = 0; i < D; i++) begin
            v[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    function automatic logic bad_bcd(input logic [W-1:0] v);
        logic r = 1'b0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic isa, input logic isb, input logic iop,
                                   input int e0);
        exp_t e;
        int   ma  = bcd2int(ia);
        int   mb  = bcd2int(ib);
        int   va  = isa ? -ma : ma;
        int   vb  = isb ? -mb : mb;
        int   r   = iop ? (va - vb) : (va + vb);
        int   mag = (r < 0) ? -r : r;
        int   lim = pow10(D);
        e.e0 = e0;
        if (bad_bcd(ia) || bad_bcd(ib)) begin
            e.s = '0; e.ss = 1'b0; e.cout = 1'b0; e.err = 1'b1; e.lat = 0;
        end else begin
            e.s    = int2bcd(mag % lim);
            e.cout = (mag >= lim);
            e.ss   = (r < 0) && ((mag % lim) != 0);
            e.err  = 1'b0;
            // Effective subtraction with |A| < |B| needs the complement pass.
            e.lat  = ((isa ^ isb ^ iop) && (ma < mb)) ? 2 * D : D;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        held.s = '0; held.ss = 1'b0; held.cout = 1'b0; held.err = 1'b0;
        held.e0 = 0; held.lat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                scoreboard.delete();
                held.s = '0; held.ss = 1'b0; held.cout = 1'b0; held.err = 1'b0;
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    check("done_one_cycle", 64'(prev_done), 64'd0);
                    if (scoreboard.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got done at cycle %0d, required no pulse", cyc);
                    end else begin
                        exp_t e;
                        int   lat;
                        e   = scoreboard.pop_front();
                        lat = cyc - e.e0;
                        check("S",    64'(s),    64'(e.s));
                        check("SS",   64'(ss),   64'(e.ss));
                        check("Cout", 64'(cout), 64'(e.cout));
                        check("err",  64'(err),  64'(e.err));
                        if (e.lat != 0) check("latency", 64'(lat), 64'(e.lat));
                        check("busy_cycles", 64'(busy_cnt), 64'(lat));
                        held = e;
                    end
                    busy_cnt = 0;
                end else begin
                    check("outputs_hold", 64'({s, ss, cout, err}),
                          64'({held.s, held.ss, held.cout, held.err}));
                end
                prev_done = done;
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; the following posedge is E0.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isa, input logic isb, input logic iop);
        a = ia; b = ib; sa = isa; sb = isb; op = iop;
        start = 1'b1;
        scoreboard.push_back(model(ia, ib, isa, isb, iop, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen.
    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                at_cyc = cyc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done in 40 cycles, required a pulse");
    endtask

    task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isa, input logic isb, input logic iop);
        int c;
        do_op(ia, ib, isa, isb, iop);
        wait_done(c);
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v = '0;
        for (int i = 0; i < D; i++) begin
            if (allow_bad && $urandom_range(0, 11) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        int c1, c2;
        #2 rst = 1'b1;
        #1 check("reset_outputs", 64'({s, ss, cout, err, busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        run(12'h123, 12'h456, 1'b0, 1'b0, 1'b0);
        check("plan_579", 64'(s), 64'h579);
        @(negedge clk);
        run(12'h999, 12'h001, 1'b0, 1'b0, 1'b0);
        check("plan_overflow", 64'({s, cout}), 64'({12'h000, 1'b1}));
        @(negedge clk);
        run(12'h123, 12'h456, 1'b0, 1'b0, 1'b1);
        check("plan_neg333", 64'({s, ss}), 64'({12'h333, 1'b1}));
        @(negedge clk);
        run(12'h500, 12'h500, 1'b1, 1'b0, 1'b0);
        check("plan_zero_pos", 64'({s, ss}), 64'({12'h000, 1'b0}));
        @(negedge clk);
        run(12'h250, 12'h100, 1'b1, 1'b1, 1'b1);
        check("plan_neg150", 64'({s, ss}), 64'({12'h150, 1'b1}));
        @(negedge clk);
        run(12'h12A, 12'h001, 1'b0, 1'b0, 1'b0);
        check("plan_err", 64'({err, s, ss, cout}), 64'({1'b1, 12'h000, 1'b0, 1'b0}));
        @(negedge clk);
        run(12'h042, 12'h007, 1'b0, 1'b0, 1'b0);
        check("plan_err_cleared", 64'({err, s}), 64'({1'b0, 12'h049}));

        // start pulsed mid-ADD with other operands must be ignored
        @(negedge clk);
        do_op(12'h111, 12'h222, 1'b0, 1'b0, 1'b0);
        a = 12'h888; b = 12'h888; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c1);
        check("mid_add_start_ignored", 64'(s), 64'h333);

        // asynchronous reset in the second ADD cycle
        @(negedge clk);
        do_op(12'h777, 12'h111, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", 64'({s, ss, cout, err, busy, done}), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_after_reset", 64'({busy, done}), 64'd0);
        run(12'h321, 12'h123, 1'b0, 1'b0, 1'b0);
        check("restart_after_reset", 64'(s), 64'h444);

        // back-to-back starts accepted in DONE
        @(negedge clk);
        do_op(12'h100, 12'h200, 1'b0, 1'b0, 1'b0);
        wait_done(c1);
        do_op(12'h300, 12'h400, 1'b0, 1'b0, 1'b0);
        wait_done(c2);
        check("b2b_spacing", 64'(c2 - c1), 64'd4);

        // randomized operations, randomly back-to-back
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] ra, rb;
            ra = rand_bcd(1'b1);
            rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd(1'b1);
            run(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 100 && scoreboard.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
